// File: rtl/spad_port_arbiter_if.sv
// Requester-side bus of the scratchpad port arbiter: request handshake plus
// per-requester read return lanes, all flattened with requester i at lane i.
interface spad_port_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 6
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0]            req_we;
   logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [N_REQ-1:0]            rsp_valid;
   logic [N_REQ*DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/spad_port_arbiter.sv
// Round-robin sharing of the two scratchpad RAM ports between N_REQ requesters,
// up to two grants per cycle, never pairing a write with a same-address access.
module spad_port_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spad_port_arbiter_if.slave    bus,
   output logic                  ram_we1,
   output logic                  ram_we2,
   output logic [ADDR_WIDTH-1:0] ram_addr1,
   output logic [ADDR_WIDTH-1:0] ram_addr2,
   output logic [DATA_WIDTH-1:0] ram_din1,
   output logic [DATA_WIDTH-1:0] ram_din2,
   input  logic [DATA_WIDTH-1:0] ram_dout1,
   input  logic [DATA_WIDTH-1:0] ram_dout2
);
   localparam int IW = $clog2(N_REQ);
   typedef logic [IW-1:0] idx_t;

   function automatic idx_t wrap_idx(input idx_t base, input int off);
      int sum_v;
      sum_v = 32'(base) + off;
      if (sum_v >= N_REQ) begin
         sum_v = sum_v - N_REQ;
      end else begin
         sum_v = sum_v;
      end
      return idx_t'(sum_v);
   endfunction

   logic [ADDR_WIDTH-1:0] addr_s  [N_REQ];
   logic [DATA_WIDTH-1:0] wdata_s [N_REQ];
   logic [N_REQ-1:0]      ready_s;
   logic [N_REQ-1:0]      rsp_valid_s;

   idx_t ptr_r;
   idx_t scan_idx_s;
   idx_t a_idx_s;
   idx_t b_idx_s;
   logic a_found_s;
   logic b_found_s;
   logic grant_a_s;
   logic grant_b_s;

   // Read-return tags: one per RAM port, lined up with the RAM's registered read data.
   logic tag1_v_r;
   logic tag2_v_r;
   idx_t tag1_idx_r;
   idx_t tag2_idx_r;

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign addr_s[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_s[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign ready_s[g] = (grant_a_s && (a_idx_s == idx_t'(g)))
                       || (grant_b_s && (b_idx_s == idx_t'(g)));
      assign rsp_valid_s[g] = rst_n && ((tag1_v_r && (tag1_idx_r == idx_t'(g)))
                                     || (tag2_v_r && (tag2_idx_r == idx_t'(g))));
      assign bus.rsp_data[g*DATA_WIDTH +: DATA_WIDTH] =
         (tag2_v_r && (tag2_idx_r == idx_t'(g))) ? ram_dout2 : ram_dout1;
   end

   // Priority scan from ptr: first valid wins port 1, first later non-conflicting one wins port 2.
   always_comb begin
      a_found_s  = 1'b0;
      a_idx_s    = '0;
      b_found_s  = 1'b0;
      b_idx_s    = '0;
      scan_idx_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx_s = wrap_idx(ptr_r, k);
         if (bus.req_valid[scan_idx_s] && !a_found_s) begin
            a_found_s = 1'b1;
            a_idx_s   = scan_idx_s;
         end else if (bus.req_valid[scan_idx_s] && !b_found_s
                      && !((addr_s[scan_idx_s] == addr_s[a_idx_s])
                           && (bus.req_we[scan_idx_s] || bus.req_we[a_idx_s]))) begin
            b_found_s = 1'b1;
            b_idx_s   = scan_idx_s;
         end else begin
            b_found_s = b_found_s;
         end
      end
   end

   assign grant_a_s = a_found_s && rst_n;
   assign grant_b_s = b_found_s && rst_n;

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = rsp_valid_s;

   // An idle port 2 mirrors port 1's address/data so its pins do not toggle.
   assign ram_we1   = grant_a_s && bus.req_we[a_idx_s];
   assign ram_addr1 = addr_s[a_idx_s];
   assign ram_din1  = wdata_s[a_idx_s];
   assign ram_we2   = grant_b_s && bus.req_we[b_idx_s];
   assign ram_addr2 = grant_b_s ? addr_s[b_idx_s]  : addr_s[a_idx_s];
   assign ram_din2  = grant_b_s ? wdata_s[b_idx_s] : wdata_s[a_idx_s];

   // Round-robin pointer and read tags; reset drops any read still in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r      <= '0;
         tag1_v_r   <= 1'b0;
         tag1_idx_r <= '0;
         tag2_v_r   <= 1'b0;
         tag2_idx_r <= '0;
      end else begin
         if (grant_b_s) begin
            ptr_r <= wrap_idx(b_idx_s, 1);
         end else if (grant_a_s) begin
            ptr_r <= wrap_idx(a_idx_s, 1);
         end else begin
            ptr_r <= ptr_r;
         end
         tag1_v_r   <= grant_a_s && !bus.req_we[a_idx_s];
         tag1_idx_r <= a_idx_s;
         tag2_v_r   <= grant_b_s && !bus.req_we[b_idx_s];
         tag2_idx_r <= b_idx_s;
      end
   end
endmodule
